mem_access_unit: RTL and testbench

Data-memory responder stage that consumes the ALU's registered memory-operation writeback (read/write, address, store data, funct3, rd address). It issues one data-memory transaction per operation over a req/ack bus and drives byte-lane enables for stores. For loads, it aligns and sign- or zero-extends the returned word, then produces a one-cycle register writeback.

---
 rtl/mem_access_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns ALU load/store writebacks into req/ack bus transactions and load writebacks.
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module mem_access_unit #(
    parameter int XLEN      = 32,
    parameter int REG_SEL_W = 5,
    parameter int BE_W      = XLEN / 8
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iMemRead,
    input  logic                 iMemWrite,
    input  logic [XLEN-1:0]      iMemAddr,
    input  logic [XLEN-1:0]      iMemData,
    input  logic [2:0]           iMemOpType,
    input  logic [REG_SEL_W-1:0] iMemRdAddr,
    output logic                 oBusy,
    output logic                 oDmReq,
    output logic                 oDmWe,
    output logic [XLEN-1:0]      oDmAddr,
    output logic [XLEN-1:0]      oDmWData,
    output logic [BE_W-1:0]      oDmBe,
    input  logic                 iDmAck,
    input  logic [XLEN-1:0]      iDmRData,
    output logic                 oRegDv,
    output logic [REG_SEL_W-1:0] oRegAddr,
    output logic [XLEN-1:0]      oRegData,
    output logic                 oErr
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   dm_req_q, dm_req_d;
    logic                   dm_we_q, dm_we_d;
    logic [XLEN-1:0]        dm_addr_q, dm_addr_d;
    logic [XLEN-1:0]        dm_wdata_q, dm_wdata_d;
    logic [BE_W-1:0]        dm_be_q, dm_be_d;
    logic                   reg_dv_q, reg_dv_d;
    logic [REG_SEL_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]        reg_data_q, reg_data_d;
    logic                   err_q, err_d;
    logic [2:0]             f3_q, f3_d;
    logic [1:0]             off_q, off_d;
    logic [XLEN-1:0]        rdata_q, rdata_d;

    logic                   op_valid;
    logic                   f3_ok;
    logic                   trap;
    logic [1:0]             eff_off;

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
        return (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    endfunction

    function automatic logic [BE_W-1:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [BE_W-1:0] be;
        case (f3[1:0])
            2'b00:   be = BE_W'(1) << off;
            2'b01:   be = BE_W'(3) << {off[1], 1'b0};
            default: be = '1;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (f3[1:0])
            2'b00:   r = {BE_W{d[7:0]}};
            2'b01:   r = {(BE_W/2){d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Shift the addressed lane down to bit 0, then extend per funct3.
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [XLEN-1:0] w);
        logic [XLEN-1:0] s;
        logic [XLEN-1:0] r;
        s = w >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{(XLEN-8){s[7]}}, s[7:0]};
            3'b001:  r = {{(XLEN-16){s[15]}}, s[15:0]};
            3'b100:  r = {{(XLEN-8){1'b0}}, s[7:0]};
            3'b101:  r = {{(XLEN-16){1'b0}}, s[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    assign trap    = misaligned(iMemOpType, iMemAddr[1:0]);
    assign eff_off = iMemAddr[1:0];
`else
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        logic [1:0] r;
        case (f3[1:0])
            2'b01:   r = {off[1], 1'b0};
            2'b10:   r = 2'b00;
            default: r = off;
        endcase
        return r;
    endfunction

    assign trap    = 1'b0;
    assign eff_off = align_off(iMemOpType, iMemAddr[1:0]);
`endif

    assign op_valid = iMemRead | iMemWrite;
    assign f3_ok    = f3_legal(iMemRead, iMemOpType);

    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_be_d    = dm_be_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        off_d      = off_q;
        rdata_d    = rdata_q;
        reg_data_d = reg_data_q;
        reg_dv_d   = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    if (!f3_ok || trap) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = REQ;
                        dm_req_d   = 1'b1;
                        dm_we_d    = ~iMemRead;
                        dm_addr_d  = {iMemAddr[XLEN-1:2], 2'b00};
                        dm_be_d    = store_be(iMemOpType, eff_off);
                        dm_wdata_d = iMemRead ? '0 : store_data(iMemOpType, iMemData);
                        f3_d       = iMemOpType;
                        off_d      = eff_off;
                        rd_d       = iMemRdAddr;
                    end
                end
            end
            REQ: begin
                if (iDmAck) begin
                    dm_req_d = 1'b0;
                    if (dm_we_q) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = iDmRData;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                // rd==0 still completes the access but never writes back.
                reg_dv_d   = (rd_q != '0);
                reg_data_d = load_ext(f3_q, off_q, rdata_q);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_be_q    <= '0;
            reg_dv_q   <= 1'b0;
            rd_q       <= '0;
            reg_data_q <= '0;
            err_q      <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_be_q    <= dm_be_d;
            reg_dv_q   <= reg_dv_d;
            rd_q       <= rd_d;
            reg_data_q <= reg_data_d;
            err_q      <= err_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            rdata_q    <= rdata_d;
        end
    end

    assign oBusy    = busy_q;
    assign oDmReq   = dm_req_q;
    assign oDmWe    = dm_we_q;
    assign oDmAddr  = dm_addr_q;
    assign oDmWData = dm_wdata_q;
    assign oDmBe    = dm_be_q;
    assign oRegDv   = reg_dv_q;
    assign oRegAddr = rd_q;
    assign oRegData = reg_data_q;
    assign oErr     = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, illegal/misaligned ops, busy drop and async reset.
module tb_mem_access_unit;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iMemRead = 1'b0;
    logic        iMemWrite = 1'b0;
    logic [31:0] iMemAddr = '0;
    logic [31:0] iMemData = '0;
    logic [2:0]  iMemOpType = '0;
    logic [4:0]  iMemRdAddr = '0;
    logic        oBusy;
    logic        oDmReq;
    logic        oDmWe;
    logic [31:0] oDmAddr;
    logic [31:0] oDmWData;
    logic [3:0]  oDmBe;
    logic        iDmAck = 1'b0;
    logic [31:0] iDmRData = '0;
    logic        oRegDv;
    logic [4:0]  oRegAddr;
    logic [31:0] oRegData;
    logic        oErr;

    int n_chk  = 0;
    int n_pass = 0;

    mem_access_unit dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iMemRead   (iMemRead),
        .iMemWrite  (iMemWrite),
        .iMemAddr   (iMemAddr),
        .iMemData   (iMemData),
        .iMemOpType (iMemOpType),
        .iMemRdAddr (iMemRdAddr),
        .oBusy      (oBusy),
        .oDmReq     (oDmReq),
        .oDmWe      (oDmWe),
        .oDmAddr    (oDmAddr),
        .oDmWData   (oDmWData),
        .oDmBe      (oDmBe),
        .iDmAck     (iDmAck),
        .iDmRData   (iDmRData),
        .oRegDv     (oRegDv),
        .oRegAddr   (oRegAddr),
        .oRegData   (oRegData),
        .oErr       (oErr)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},  32'(oBusy), 32'd0);
        check({tag, " req"},   32'(oDmReq), 32'd0);
        check({tag, " we"},    32'(oDmWe), 32'd0);
        check({tag, " addr"},  oDmAddr, 32'd0);
        check({tag, " wdata"}, oDmWData, 32'd0);
        check({tag, " be"},    32'(oDmBe), 32'd0);
        check({tag, " dv"},    32'(oRegDv), 32'd0);
        check({tag, " rd"},    32'(oRegAddr), 32'd0);
        check({tag, " rdata"}, oRegData, 32'd0);
        check({tag, " err"},   32'(oErr), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic is_load, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rdata, input int ack_wait, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_reg, input logic exp_dv);
        iMemRead   = is_load;
        iMemWrite  = !is_load;
        iMemAddr   = addr;
        iMemData   = wdata;
        iMemOpType = f3;
        iMemRdAddr = rd;
        tick();
        iMemRead  = 1'b0;
        iMemWrite = 1'b0;
        check({tag, " req"},  32'(oDmReq), 32'd1);
        check({tag, " we"},   32'(oDmWe), 32'(!is_load));
        check({tag, " addr"}, oDmAddr, {addr[31:2], 2'b00});
        check({tag, " busy"}, 32'(oBusy), 32'd1);
        check({tag, " err"},  32'(oErr), 32'd0);
        if (!is_load) begin
            check({tag, " be"},    32'(oDmBe), 32'(exp_be));
            check({tag, " wdata"}, oDmWData, exp_wd);
        end
        for (int i = 0; i < ack_wait; i++) begin
            tick();
            check({tag, " req hold"}, 32'(oDmReq), 32'd1);
        end
        iDmAck   = 1'b1;
        iDmRData = rdata;
        tick();
        iDmAck   = 1'b0;
        iDmRData = '0;
        check({tag, " req drop"}, 32'(oDmReq), 32'd0);
        check({tag, " dv early"}, 32'(oRegDv), 32'd0);
        if (is_load) begin
            tick();
            check({tag, " dv"}, 32'(oRegDv), 32'(exp_dv));
            if (exp_dv) begin
                check({tag, " regdata"}, oRegData, exp_reg);
                check({tag, " regaddr"}, 32'(oRegAddr), 32'(rd));
            end
        end
        check({tag, " idle"}, 32'(oBusy), 32'd0);
        tick();
        check({tag, " dv end"}, 32'(oRegDv), 32'd0);
    endtask

    task automatic run_err(input string tag, input logic is_load, input logic [31:0] addr,
                           input logic [2:0] f3);
        iMemRead   = is_load;
        iMemWrite  = !is_load;
        iMemAddr   = addr;
        iMemOpType = f3;
        iMemRdAddr = 5'd4;
        tick();
        iMemRead  = 1'b0;
        iMemWrite = 1'b0;
        check({tag, " err"},  32'(oErr), 32'd1);
        check({tag, " req"},  32'(oDmReq), 32'd0);
        check({tag, " busy"}, 32'(oBusy), 32'd0);
        tick();
        check({tag, " err end"}, 32'(oErr), 32'd0);
        check({tag, " req end"}, 32'(oDmReq), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        iRst = 1'b1;
        tick();

        // Loads: LB, LHU, LH, LW, LBU, LB
        run_op("lb",  1'b1, 32'h103, 32'h0, 3'b000, 5'd5, 32'h80FF_1234, 2, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b1);
        run_op("lhu", 1'b1, 32'h202, 32'h0, 3'b101, 5'd6, 32'hBEEF_0000, 1, 4'h0, 32'h0, 32'h0000_BEEF, 1'b1);
        run_op("lh",  1'b1, 32'h202, 32'h0, 3'b001, 5'd6, 32'hBEEF_0000, 0, 4'h0, 32'h0, 32'hFFFF_BEEF, 1'b1);
        run_op("lw",  1'b1, 32'h100, 32'h0, 3'b010, 5'd31, 32'h1234_5678, 0, 4'h0, 32'h0, 32'h1234_5678, 1'b1);
        run_op("lbu", 1'b1, 32'h105, 32'h0, 3'b100, 5'd2, 32'h0000_A500, 1, 4'h0, 32'h0, 32'h0000_00A5, 1'b1);
        run_op("lb1", 1'b1, 32'h105, 32'h0, 3'b000, 5'd2, 32'h0000_A500, 0, 4'h0, 32'h0, 32'hFFFF_FFA5, 1'b1);

        // Stores: SB, SH, SW
        run_op("sb", 1'b0, 32'h301, 32'h0000_00A5, 3'b000, 5'd0, 32'h0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0);
        run_op("sh", 1'b0, 32'h302, 32'h0000_1234, 3'b001, 5'd0, 32'h0, 1, 4'b1100, 32'h1234_1234, 32'h0, 1'b0);
        run_op("sw", 1'b0, 32'h304, 32'hDEAD_BEEF, 3'b010, 5'd0, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);

        // Load to x0 with immediate ack: access happens, no writeback
        run_op("lw x0", 1'b1, 32'h108, 32'h0, 3'b010, 5'd0, 32'hCAFE_F00D, 0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Op presented while busy is dropped
        iMemRead = 1'b1; iMemAddr = 32'h10; iMemOpType = 3'b010; iMemRdAddr = 5'd3;
        tick();
        iMemRead = 1'b0;
        iMemWrite = 1'b1; iMemAddr = 32'h20; iMemData = 32'h5555_5555;
        tick();
        iMemWrite = 1'b0;
        check("drop addr", oDmAddr, 32'h10);
        check("drop we", 32'(oDmWe), 32'd0);
        iDmAck = 1'b1; iDmRData = 32'h0000_0042;
        tick();
        iDmAck = 1'b0;
        tick();
        check("drop first dv", 32'(oRegDv), 32'd1);
        check("drop first data", oRegData, 32'h0000_0042);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drop no req", 32'(oDmReq), 32'd0);
        end

        // Misaligned LW
`ifdef MEM_MISALIGN_TRAP_EN
        run_err("lw misalign", 1'b1, 32'h401, 3'b010);
        run_err("sh misalign", 1'b0, 32'h403, 3'b001);
`else
        run_op("lw misalign", 1'b1, 32'h401, 32'h0, 3'b010, 5'd9, 32'h1122_3344, 0, 4'h0, 32'h0, 32'h1122_3344, 1'b1);
        run_op("lh misalign", 1'b1, 32'h403, 32'h0, 3'b001, 5'd9, 32'h8001_7FFF, 0, 4'h0, 32'h0, 32'hFFFF_8001, 1'b1);
        run_op("sh misalign", 1'b0, 32'h403, 32'h0000_ABCD, 3'b001, 5'd0, 32'h0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);
`endif

        // Illegal funct3
        run_err("ld f3=011", 1'b1, 32'h500, 3'b011);
        run_err("ld f3=110", 1'b1, 32'h500, 3'b110);
        run_err("st f3=100", 1'b0, 32'h500, 3'b100);

        // Reset in the middle of a load
        iMemRead = 1'b1; iMemAddr = 32'h50; iMemOpType = 3'b010; iMemRdAddr = 5'd7;
        tick();
        iMemRead = 1'b0;
        check("rst pre req", 32'(oDmReq), 32'd1);
        #2 iRst = 1'b0;
        #1;
        check_all_zero("rst mid");
        tick();
        iRst = 1'b1;
        iDmAck = 1'b1; iDmRData = 32'hFFFF_FFFF;
        tick();
        iDmAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late ack dv", 32'(oRegDv), 32'd0);
            check("late ack req", 32'(oDmReq), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
